// File: rtl/adder_unit_if.sv
// ----------------------------------------------------------------------------
// adder_unit_if
//   Operand/result bundle for adder_unit.
//
//   Parameter:
//     WIDTH      operand and sum width in bits (>= 1)
//
//   Signals:
//     in_valid   operand set a, b, cin is presented this cycle
//     a, b       operands (unsigned or two's complement)
//     cin        carry-in
//     sum        registered (a + b + cin) mod 2^WIDTH
//     cout       registered carry out of the MSB
//     ovf        registered signed overflow
//     zero       registered sum == 0 flag
//     out_valid  one-cycle pulse per accepted operand set
//
//   Modports:
//     master     operand source / result sink (testbench or parent)
//     slave      the adder itself
// ----------------------------------------------------------------------------
interface adder_unit_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  sum, cout, ovf, zero, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, cout, ovf, zero, out_valid
    );
endinterface

// File: rtl/adder_unit.sv
// ----------------------------------------------------------------------------
// adder_unit
//   Registered, width-parameterized binary adder with carry-in, carry-out,
//   signed-overflow and zero flags. At WIDTH = 1 it is a clocked full adder.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset (clears results and valid)
//     bus   adder_unit_if.slave: in_valid/a/b/cin in, sum/cout/ovf/zero/
//           out_valid out
//
//   Parameter:
//     WIDTH operand width (>= 1), must match the connected interface
//
//   Build option:
//     ADDER_PIPE2_EN  undefined -> single stage, latency 1
//                     defined   -> two stages (low half, then high half),
//                                  latency 2; results and flags identical
//
//   Result registers only load when a result is presented, so outputs hold
//   their last value between accepted operand sets and undriven operands
//   while in_valid = 0 never reach them.
// ----------------------------------------------------------------------------
module adder_unit #(
    parameter int WIDTH = 1
) (
    input  logic      clk,
    input  logic      rst,
    adder_unit_if.slave bus
);

    // Result presented to the output register stage this cycle.
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_msb_cin;   // carry into the MSB, for overflow
    logic             res_fire;

    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             valid_reg;

`ifdef ADDER_PIPE2_EN
    // Low half is the larger half when WIDTH is odd, so WIDTH = 1 leaves an
    // empty high half and stage 2 only forwards.
    localparam int LO_W = (WIDTH + 1) / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [LO_W:0]   lo_full;
    logic [LO_W-1:0] lo_sum_reg;
    logic            lo_carry_reg;
    logic            s1_valid_reg;

    assign lo_full = {1'b0, bus.a[LO_W-1:0]} + {1'b0, bus.b[LO_W-1:0]}
                   + {{LO_W{1'b0}}, bus.cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_sum_reg   <= '0;
            lo_carry_reg <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                lo_sum_reg   <= lo_full[LO_W-1:0];
                lo_carry_reg <= lo_full[LO_W];
            end
        end
    end

    generate
        if (HI_W > 0) begin : g_hi
            logic [HI_W-1:0] a_hi_reg;
            logic [HI_W-1:0] b_hi_reg;
            logic [HI_W:0]   hi_full;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hi_reg <= '0;
                    b_hi_reg <= '0;
                end else if (bus.in_valid) begin
                    a_hi_reg <= bus.a[WIDTH-1:LO_W];
                    b_hi_reg <= bus.b[WIDTH-1:LO_W];
                end
            end

            assign hi_full     = {1'b0, a_hi_reg} + {1'b0, b_hi_reg}
                               + {{HI_W{1'b0}}, lo_carry_reg};
            assign res_sum     = {hi_full[HI_W-1:0], lo_sum_reg};
            assign res_cout    = hi_full[HI_W];
            // sum bit = a ^ b ^ carry_in, so the carry in is recoverable.
            assign res_msb_cin = a_hi_reg[HI_W-1] ^ b_hi_reg[HI_W-1]
                               ^ hi_full[HI_W-1];
        end else begin : g_no_hi
            // MSB lives in the low half; capture its carry-in in stage 1.
            logic msb_cin_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    msb_cin_reg <= 1'b0;
                end else if (bus.in_valid) begin
                    msb_cin_reg <= bus.a[LO_W-1] ^ bus.b[LO_W-1]
                                 ^ lo_full[LO_W-1];
                end
            end

            assign res_sum     = lo_sum_reg;
            assign res_cout    = lo_carry_reg;
            assign res_msb_cin = msb_cin_reg;
        end
    endgenerate

    assign res_fire = s1_valid_reg;
`else
    logic [WIDTH:0] full;

    assign full        = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    assign res_sum     = full[WIDTH-1:0];
    assign res_cout    = full[WIDTH];
    assign res_msb_cin = bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ full[WIDTH-1];
    assign res_fire    = bus.in_valid;
`endif

    // Output stage shared by both builds, so flags and reset values match.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= res_fire;
            if (res_fire) begin
                sum_reg  <= res_sum;
                cout_reg <= res_cout;
                ovf_reg  <= res_msb_cin ^ res_cout;
                zero_reg <= (res_sum == '0);
            end
        end
    end

    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;
    assign bus.out_valid = valid_reg;

endmodule

// File: tb/tb_adder_unit.sv
// ----------------------------------------------------------------------------
// tb_adder_unit
//   Scoreboard bench for adder_unit at WIDTH = 1 and WIDTH = 8. Stimulus
//   pushes hand-computed expected results (with the cycle they are due) into
//   per-instance queues; negedge monitors pop and compare on out_valid.
// ----------------------------------------------------------------------------
module tb_adder_unit;

`ifdef ADDER_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q1[$];
    exp_t q8[$];

    adder_unit_if #(.WIDTH(1)) bus1 ();
    adder_unit_if #(.WIDTH(8)) bus8 ();

    adder_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    adder_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.out_valid === 1'b1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL w1_spurious: out_valid=1 at cycle %0d, required no pending result", cyc);
            end else begin
                e = q1.pop_front();
                if ({7'b0, bus1.sum} !== e.sum || bus1.cout !== e.cout ||
                    bus1.ovf !== e.ovf || bus1.zero !== e.zero || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL w1_result: got sum=%b cout=%b ovf=%b zero=%b cyc=%0d, required sum=%b cout=%b ovf=%b zero=%b cyc=%0d",
                             bus1.sum, bus1.cout, bus1.ovf, bus1.zero, cyc,
                             e.sum[0], e.cout, e.ovf, e.zero, e.due);
                end else begin
                    $display("w1 cyc=%0d sum=%b cout=%b ovf=%b zero=%b ok",
                             cyc, bus1.sum, bus1.cout, bus1.ovf, bus1.zero);
                end
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (bus8.out_valid === 1'b1) begin
            n_cmp++;
            if (q8.size() == 0) begin
                n_bad++;
                $display("FAIL w8_spurious: out_valid=1 at cycle %0d sum=%h, required no pending result", cyc, bus8.sum);
            end else begin
                e = q8.pop_front();
                if (bus8.sum !== e.sum || bus8.cout !== e.cout ||
                    bus8.ovf !== e.ovf || bus8.zero !== e.zero || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL w8_result: got sum=%h cout=%b ovf=%b zero=%b cyc=%0d, required sum=%h cout=%b ovf=%b zero=%b cyc=%0d",
                             bus8.sum, bus8.cout, bus8.ovf, bus8.zero, cyc,
                             e.sum, e.cout, e.ovf, e.zero, e.due);
                end else begin
                    $display("w8 cyc=%0d sum=%h cout=%b ovf=%b zero=%b ok",
                             cyc, bus8.sum, bus8.cout, bus8.ovf, bus8.zero);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic issue1(input logic a, input logic b, input logic cin,
                          input logic s, input logic c, input logic o, input logic z);
        exp_t e;
        bus1.in_valid = 1'b1;
        bus1.a = a;
        bus1.b = b;
        bus1.cin = cin;
        e.sum = {7'b0, s};
        e.cout = c;
        e.ovf = o;
        e.zero = z;
        e.due = cyc + LAT;
        q1.push_back(e);
        tick();
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] s, input logic c, input logic o,
                          input logic z, input bit push);
        exp_t e;
        bus8.in_valid = 1'b1;
        bus8.a = a;
        bus8.b = b;
        bus8.cin = cin;
        e.sum = s;
        e.cout = c;
        e.ovf = o;
        e.zero = z;
        e.due = cyc + LAT;
        if (push) q8.push_back(e);
        tick();
    endtask

    task automatic idle(input int n);
        bus1.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // WIDTH = 1 full-adder truth table: {a,b,cin} -> {sum,cout,ovf,zero}
    logic [3:0] fa_tab [8] = '{4'b0_0_0_1, 4'b1_0_1_0, 4'b1_0_0_0, 4'b0_1_0_1,
                               4'b1_0_0_0, 4'b0_1_0_1, 4'b0_1_1_1, 4'b1_1_0_0};

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b0;
        bus8.in_valid = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0;

        // Reset held with valid operands present: nothing may come out.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_w1_valid", {31'b0, bus1.out_valid}, 32'd0);
            chk("rst_w1_sum_cout", {30'b0, bus1.sum, bus1.cout}, 32'd0);
            chk("rst_w8_valid", {31'b0, bus8.out_valid}, 32'd0);
            chk("rst_w8_sum_cout", {23'b0, bus8.sum, bus8.cout}, 32'd0);
        end
        tick();
        rst = 1'b0;
        idle(2);

        // WIDTH = 1 exhaustive, back to back.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [3:0] r;
            v = i[2:0];
            r = fa_tab[i];
            issue1(v[2], v[1], v[0], r[3], r[2], r[1], r[0]);
        end
        idle(4);

        // WIDTH = 8 directed vectors, back to back.
        issue8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);  // wrap
        issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);  // +ovf
        issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);  // -ovf
        issue8(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        issue8(8'h64, 8'hC8, 1'b1, 8'h2D, 1'b1, 1'b0, 1'b0, 1'b1);
        issue8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);

        // Hold: one accepted set, then random operands with in_valid low.
        issue8(8'h12, 8'h2A, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        bus8.in_valid = 1'b0;
        repeat (LAT + 1) begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_sum", {24'b0, bus8.sum}, 32'h3C);
            chk("hold_valid", {31'b0, bus8.out_valid}, 32'd0);
            tick();
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        end
        idle(2);

        // Mid-stream reset: the second set arrives together with rst. With
        // the two-stage build neither set may emerge; single-stage emits set 1.
        issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, (LAT == 1));
        rst = 1'b1;
        issue8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_sum", {24'b0, bus8.sum}, 32'd0);
        chk("mid_rst_flags", {28'b0, bus8.cout, bus8.ovf, bus8.zero, bus8.out_valid}, 32'd0);
        tick();
        idle(6);

        chk("w1_queue_drained", q1.size(), 32'd0);
        chk("w8_queue_drained", q8.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
